piso_serializer: RTL

Parametrised parallel-in/serial-out serializer with a valid/ready load port, selectable bit order and framed serial output. It accepts WIDTH-bit words from an upstream producer and shifts them out one bit per clock, marking the start and end of each word. A one-entry holding register lets the next word be accepted while the current one is still shifting, so back-to-back words stream with no idle gap. It replaces the fixed 4-bit, reset-loaded shifter in serial link and display-driver datapaths.

---
 rtl/piso_pkg.sv | 11 +
 rtl/piso_serializer_if.sv | 23 ++
 rtl/piso_hold_reg.sv | 32 +++
 rtl/piso_serializer.sv | 96 +++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {StIdle, StShift} state_e;

  // Bit-counter width; never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and framed serial output of the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
  );
endinterface

// File: rtl/piso_hold_reg.sv
// One-entry holding register that queues the next word while the current one shifts.
module piso_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (wr_en_i) begin
      data_q <= din_i;
      full_q <= 1'b1;
    end else if (rd_en_i) begin
      full_q <= 1'b0;
    end
  end

  assign dout_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: shift register, bit counter and framing FSM.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  localparam int unsigned     CntW    = cnt_w(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]   bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]  hold_dout;
  logic              hold_full;
  logic              hold_wr;
  logic              hold_rd;
  logic              accept;
  logic              shifting;

  assign accept   = bus.in_valid & ~hold_full;
  assign shifting = (state_q == StShift);

  piso_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (hold_wr),
    .din_i   (bus.in_data),
    .rd_en_i (hold_rd),
    .dout_o  (hold_dout),
    .full_o  (hold_full)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    hold_wr  = 1'b0;
    hold_rd  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shreg_d  = bus.in_data;
          bitcnt_d = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (bitcnt_q != LastCnt) begin
          shreg_d  = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          bitcnt_d = bitcnt_q + 1'b1;
          hold_wr  = accept;
        end else if (hold_full) begin
          // in_ready is low here, so no accept can collide with the hold drain.
          shreg_d  = hold_dout;
          hold_rd  = 1'b1;
          bitcnt_d = '0;
        end else if (accept) begin
          shreg_d  = bus.in_data;
          bitcnt_d = '0;
        end else begin
          shreg_d  = '0;
          bitcnt_d = '0;
          state_d  = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  assign bus.in_ready  = ~hold_full;
  assign bus.ser_valid = shifting;
  assign bus.ser_out   = shifting & (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);
  assign bus.ser_first = shifting & (bitcnt_q == '0);
  assign bus.ser_last  = shifting & (bitcnt_q == LastCnt);
  assign bus.busy      = shifting | hold_full;

endmodule
